mod_mult_sched: RTL

- Shares one pipelined Barrett modular multiplier (mod_multiplier_barrett_64b_pp, 12-cycle latency) among NREQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle.
- Each in-flight operation is tagged with its requester index, and the result is returned to that requester.
- The block owns the multiplier's precomputed configuration (K, U, Mod). Because Mod is consumed late in that pipeline without being delayed alongside the data, a configuration change is applied only after the pipeline drains.

---
 rtl/mod_mult_sched.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mod_mult_sched.sv
// -----------------------------------------------------------------------------
// mod_mult_sched
//
// Shares a single pipelined Barrett modular multiplier between NREQ
// requesters. A round-robin arbiter issues at most one operand pair per cycle.
// Each issued operation carries its requester index down a tag pipeline that
// runs in lock-step with the multiplier, so every result is steered back to
// the requester that issued it.
//
// The block also owns the multiplier configuration (K, U, Mod). The
// multiplier reads Mod late in its pipeline and does not delay it alongside
// the data. A new configuration is therefore only loaded after every
// in-flight operation has returned (RUN -> DRAIN -> CFG -> RUN).
//
// Ports
//   iClk, iRst          clock (rising edge), asynchronous active-high reset
//   iCfgValid/iCfgK/iCfgU/iCfgMod
//                       configuration offer; held until oCfgReady is seen
//   oCfgReady           configuration accepted this cycle (CFG state)
//   iFlush              abort all in-flight operations
//   iReqValid           per-requester request
//   iReqData0/1         packed operands; requester i at [i*DW +: DW]
//   oReqReady           one-hot grant (combinational)
//   oMulEn/oMulClr      multiplier enable / clear
//   oMulK/oMulU/oMulMod multiplier configuration
//   oMulData0/1         registered operands presented to the multiplier
//   iMulData            multiplier result
//   oRespValid          one-hot result strobe
//   oRespData           result
//   oBusy               operations in flight
// -----------------------------------------------------------------------------
module mod_mult_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 64,
  parameter int LATENCY = 12
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iCfgValid,
  input  logic [6:0]          iCfgK,
  input  logic [2*DW-1:0]     iCfgU,
  input  logic [DW-1:0]       iCfgMod,
  output logic                oCfgReady,
  input  logic                iFlush,
  input  logic [NREQ-1:0]     iReqValid,
  input  logic [NREQ*DW-1:0]  iReqData0,
  input  logic [NREQ*DW-1:0]  iReqData1,
  output logic [NREQ-1:0]     oReqReady,
  output logic                oMulEn,
  output logic                oMulClr,
  output logic [6:0]          oMulK,
  output logic [2*DW-1:0]     oMulU,
  output logic [DW-1:0]       oMulMod,
  output logic [DW-1:0]       oMulData0,
  output logic [DW-1:0]       oMulData1,
  input  logic [DW-1:0]       iMulData,
  output logic [NREQ-1:0]     oRespValid,
  output logic [DW-1:0]       oRespData,
  output logic                oBusy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // In-flight count spans 0..LATENCY+2.
  localparam int CW = $clog2(LATENCY + 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    CFG   = 2'd3
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   inflight_nxt_s;

  // Tag pipeline: stage 0 is loaded on the grant edge; the last stage lines
  // up with the multiplier result on iMulData.
  logic            tag_vld_r [0:LATENCY];
  logic [IW-1:0]   tag_idx_r [0:LATENCY];

  logic [IW:0]     pick_s;
  logic            grant_vld_s;
  logic [IW-1:0]   grant_idx_s;
  logic [DW-1:0]   opa_s;
  logic [DW-1:0]   opb_s;
  logic            resp_any_s;

  // First requesting index at or after ptr, wrapping; MSB flags "found".
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req,
                                          input logic [IW-1:0]   ptr);
    logic [IW:0]   res;
    logic [IW-1:0] cand;
    res = {(IW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!res[IW] && req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] res;
    res      = {NREQ{1'b0}};
    res[idx] = 1'b1;
    return res;
  endfunction

  // Round-robin arbitration; grants only in RUN and never during a flush.
  always_comb begin
    pick_s      = rr_pick(iReqValid, rr_ptr_r);
    grant_idx_s = pick_s[IW-1:0];
    if ((state_r == RUN) && !iFlush) begin
      grant_vld_s = pick_s[IW];
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  assign oReqReady  = grant_vld_s ? onehot(grant_idx_s) : {NREQ{1'b0}};
  assign oMulClr    = iFlush;
  assign resp_any_s = |oRespValid;

  // Operand mux for the granted requester.
  always_comb begin
    opa_s = {DW{1'b0}};
    opb_s = {DW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx_s == IW'(k)) begin
        opa_s = iReqData0[k*DW +: DW];
        opb_s = iReqData1[k*DW +: DW];
      end else begin
        opa_s = opa_s;
        opb_s = opb_s;
      end
    end
  end

  // Next in-flight count: +1 per grant, -1 per delivered result.
  always_comb begin
    if (iFlush) begin
      inflight_nxt_s = {CW{1'b0}};
    end else begin
      case ({grant_vld_s, resp_any_s})
        2'b10:   inflight_nxt_s = inflight_r + CW'(1);
        2'b01:   inflight_nxt_s = inflight_r - CW'(1);
        default: inflight_nxt_s = inflight_r;
      endcase
    end
  end

  // Control FSM with registered enable, config handshake and config registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r   <= IDLE;
      oCfgReady <= 1'b0;
      oMulEn    <= 1'b0;
      oMulK     <= 7'd0;
      oMulU     <= {(2*DW){1'b0}};
      oMulMod   <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (iCfgValid) begin
            state_r   <= CFG;
            oCfgReady <= 1'b1;
            oMulEn    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            oCfgReady <= 1'b0;
            oMulEn    <= 1'b0;
          end
        end
        CFG: begin
          state_r   <= RUN;
          oCfgReady <= 1'b0;
          oMulEn    <= 1'b1;
          oMulK     <= iCfgK;
          oMulU     <= iCfgU;
          oMulMod   <= iCfgMod;
        end
        RUN: begin
          // A flush keeps RUN; a pending config still moves to DRAIN.
          state_r   <= iCfgValid ? DRAIN : RUN;
          oCfgReady <= 1'b0;
          oMulEn    <= 1'b1;
        end
        DRAIN: begin
          // A flush empties the pipeline, so the drain is already complete.
          if (iFlush || (inflight_r == {CW{1'b0}})) begin
            state_r   <= CFG;
            oCfgReady <= 1'b1;
          end else begin
            state_r   <= DRAIN;
            oCfgReady <= 1'b0;
          end
          oMulEn <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          oCfgReady <= 1'b0;
          oMulEn    <= 1'b0;
        end
      endcase
    end
  end

  // Operand registers and round-robin pointer; both hold when nothing is granted.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oMulData0 <= {DW{1'b0}};
      oMulData1 <= {DW{1'b0}};
      rr_ptr_r  <= {IW{1'b0}};
    end else if (grant_vld_s) begin
      oMulData0 <= opa_s;
      oMulData1 <= opb_s;
      if (grant_idx_s == IW'(NREQ - 1)) begin
        rr_ptr_r <= {IW{1'b0}};
      end else begin
        rr_ptr_r <= grant_idx_s + IW'(1);
      end
    end
  end

  // Tag pipeline, advancing in step with the multiplier enable.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k <= LATENCY; k++) begin
        tag_vld_r[k] <= 1'b0;
        tag_idx_r[k] <= {IW{1'b0}};
      end
    end else if (iFlush) begin
      for (int k = 0; k <= LATENCY; k++) begin
        tag_vld_r[k] <= 1'b0;
      end
    end else if (oMulEn) begin
      tag_vld_r[0] <= grant_vld_s;
      tag_idx_r[0] <= grant_idx_s;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_idx_r[k] <= tag_idx_r[k-1];
      end
    end
  end

  // Result return: capture iMulData and strobe the owning requester.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oRespValid <= {NREQ{1'b0}};
      oRespData  <= {DW{1'b0}};
    end else if (iFlush) begin
      oRespValid <= {NREQ{1'b0}};
    end else if (oMulEn && tag_vld_r[LATENCY]) begin
      oRespValid <= onehot(tag_idx_r[LATENCY]);
      oRespData  <= iMulData;
    end else begin
      oRespValid <= {NREQ{1'b0}};
    end
  end

  // In-flight counter and its registered nonzero flag.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      inflight_r <= {CW{1'b0}};
      oBusy      <= 1'b0;
    end else begin
      inflight_r <= inflight_nxt_s;
      oBusy      <= (inflight_nxt_s != {CW{1'b0}});
    end
  end

endmodule
